gc_poll_engine: RTL and testbench

Host-side GameCube controller poller that drives the `controller_data` open-drain line of the `gc` top level. It transmits the 24-bit poll command, then deserialises the controller's 64-bit button/stick report. It presents the report to the fabric register interface with a one-cycle valid strobe. The block sits directly behind the `controller_data` pad: the pad's output enable is driven from `data_oe` (drive low when 1, release when 0) and the pad's input feeds `data_in`.

---
 rtl/gc_pkg.sv | 40 ++++
 rtl/gc_us_timer.sv | 34 +++
 rtl/gc_poll_engine.sv | 146 ++++++++++++++
 tb/tb_gc_poll_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared GameCube controller definitions: poll command, poller state encoding
// and the bit layout of the 64-bit controller report.
package gc_pkg;

   localparam logic [15:0] GC_CMD_POLL = 16'h4003;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_TX      = 3'd1;
   localparam logic [2:0] ST_TX_STOP = 3'd2;
   localparam logic [2:0] ST_RX_WAIT = 3'd3;
   localparam logic [2:0] ST_RX_BIT  = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_ERR     = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_TX      = ST_TX,
      S_TX_STOP = ST_TX_STOP,
      S_RX_WAIT = ST_RX_WAIT,
      S_RX_BIT  = ST_RX_BIT,
      S_DONE    = ST_DONE,
      S_ERR     = ST_ERR
   } gc_poll_state_t;

   // Report fields, LSB offsets (MSB = first bit on the wire)
   localparam int RPT_BUTTONS_LSB = 48;
   localparam int RPT_BUTTONS_W   = 16;
   localparam int RPT_JOY_X_LSB   = 40;
   localparam int RPT_JOY_Y_LSB   = 32;
   localparam int RPT_C_X_LSB     = 24;
   localparam int RPT_C_Y_LSB     = 16;
   localparam int RPT_L_LSB       = 8;
   localparam int RPT_R_LSB       = 0;
   localparam int RPT_AXIS_W      = 8;

   function automatic int gc_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gc_us_timer.sv
// Microsecond tick generator plus saturating microsecond counter, both
// restarted by a synchronous clear.
module gc_us_timer
   import gc_pkg::*;
#(
   parameter int CLK_PER_US = 10,
   parameter int MAX_US     = 100,
   localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1,
   localparam int UW = $clog2(MAX_US + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   output logic          tick,
   output logic [UW-1:0] us
);

   logic [CW-1:0] cyc;

   assign tick = (cyc == CW'(CLK_PER_US - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cyc <= '0;
         us  <= '0;
      end else if (tick) begin
         cyc <= '0;
         if (us != UW'(MAX_US)) us <= us + 1'b1;
      end else begin
         cyc <= cyc + 1'b1;
      end
   end

endmodule

// File: rtl/gc_poll_engine.sv
// Host-side GameCube poller: sends the 24-bit poll command on the open-drain
// line, then deserialises the 64-bit controller report.
module gc_poll_engine
   import gc_pkg::*;
#(
   parameter int CLK_PER_US = 10,
   parameter int TIMEOUT_US = 100,
   parameter int BIT_GAP_US = 8
) (
   input  logic        SYSCLK,
   input  logic        NSYSRESET,
   input  logic        start,
   input  logic        rumble,
   input  logic        data_in,
   output logic        data_oe,
   output logic        busy,
   output logic [63:0] report,
   output logic        valid,
   output logic        err,
   output logic [2:0]  state
);

   localparam int MAX_US = gc_max(gc_max(TIMEOUT_US, BIT_GAP_US), 4);
   localparam int UW     = $clog2(MAX_US + 1);

   logic [2:0]    st, nxt;
   logic [1:0]    sync;
   logic          prev, line, fall;
   logic [23:0]   cmd;
   logic [4:0]    bit_idx;
   logic [63:0]   shift, shift_nx;
   logic [6:0]    nbits;
   logic          sampled;
   logic          t_clear, tick;
   logic [UW-1:0] us;
   logic          accept, tx_bit, bit_end, sample_now, done_now;

   gc_us_timer #(
      .CLK_PER_US (CLK_PER_US),
      .MAX_US     (MAX_US)
   ) u_timer (
      .clk   (SYSCLK),
      .rst_n (NSYSRESET),
      .clear (t_clear),
      .tick  (tick),
      .us    (us)
   );

   assign line       = sync[1];
   assign fall       = prev & ~line;
   assign accept     = start && (st == ST_IDLE || st == ST_DONE || st == ST_ERR);
   assign tx_bit     = (st == ST_TX) ? cmd[5'd23 - bit_idx] : 1'b1;
   assign bit_end    = tick && (us == UW'(3));
   assign sample_now = (st == ST_RX_BIT) && !sampled && tick && (us == UW'(1));
   assign done_now   = sample_now && (nbits == 7'd63);
   assign shift_nx   = {shift[62:0], line};

   always_comb begin
      nxt     = st;
      t_clear = 1'b0;
      case (st)
         ST_TX: begin
            if (bit_end) begin
               t_clear = 1'b1;
               if (bit_idx == 5'd23) nxt = ST_TX_STOP;
            end
         end
         ST_TX_STOP: begin
            if (bit_end) begin
               t_clear = 1'b1;
               nxt     = ST_RX_WAIT;
            end
         end
         ST_RX_WAIT: begin
            if (fall) begin
               t_clear = 1'b1;
               nxt     = ST_RX_BIT;
            end else if (tick && us == UW'(TIMEOUT_US - 1)) begin
               nxt = ST_ERR;
            end
         end
         ST_RX_BIT: begin
            // Falls before the sample point are not bit boundaries and are ignored
            if (done_now) begin
               nxt = ST_DONE;
            end else if (sampled && fall) begin
               t_clear = 1'b1;
            end else if (tick && us == UW'(BIT_GAP_US - 1)) begin
               nxt = ST_ERR;
            end
         end
         default: begin
            if (start) begin
               t_clear = 1'b1;
               nxt     = ST_TX;
            end else begin
               nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge SYSCLK) begin
      if (!NSYSRESET) begin
         st      <= ST_IDLE;
         sync    <= 2'b11;
         prev    <= 1'b1;
         cmd     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         nbits   <= '0;
         sampled <= 1'b0;
         report  <= '0;
      end else begin
         st   <= nxt;
         sync <= {sync[0], data_in};
         prev <= line;
         if (accept) begin
            cmd     <= {GC_CMD_POLL, 7'b0, rumble};
            bit_idx <= '0;
            shift   <= '0;
            nbits   <= '0;
            sampled <= 1'b0;
         end
         if (st == ST_TX && bit_end) bit_idx <= bit_idx + 5'd1;
         if (sample_now) begin
            shift   <= shift_nx;
            nbits   <= nbits + 7'd1;
            sampled <= 1'b1;
         end else if (st == ST_RX_BIT && sampled && fall) begin
            sampled <= 1'b0;
         end
         if (done_now) report <= shift_nx;
      end
   end

   // A '1' holds the line low for 1 us of 4, a '0' for 3 us of 4
   assign data_oe = (st == ST_TX || st == ST_TX_STOP) &&
                    (tx_bit ? (us == UW'(0)) : (us < UW'(3)));
   assign busy    = (st == ST_TX) || (st == ST_TX_STOP) ||
                    (st == ST_RX_WAIT) || (st == ST_RX_BIT);
   assign valid   = (st == ST_DONE);
   assign err     = (st == ST_ERR);
   assign state   = st;

endmodule

// File: tb/tb_gc_poll_engine.sv
// Bench for gc_poll_engine: a timeline model of each poll predicts every output
// on every cycle; a report queue checks each published report.
module tb_gc_poll_engine;
   import gc_pkg::*;

   logic        SYSCLK = 1'b0;
   logic        NSYSRESET = 1'b0;
   logic        start = 1'b0;
   logic        rumble = 1'b0;
   logic        data_in = 1'b1;
   logic        data_oe, busy, valid, err;
   logic [63:0] report;
   logic [2:0]  state;

   gc_poll_engine dut (
      .SYSCLK    (SYSCLK),
      .NSYSRESET (NSYSRESET),
      .start     (start),
      .rumble    (rumble),
      .data_in   (data_in),
      .data_oe   (data_oe),
      .busy      (busy),
      .report    (report),
      .valid     (valid),
      .err       (err),
      .state     (state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 SYSCLK = ~SYSCLK;

   int cyc = 0;
   always @(posedge SYSCLK) cyc++;

   // ---------------- model of the current poll ----------------
   bit          act = 1'b0;
   int          t0 = 0, nresp = 0, dly = 0, end_rel = 0;
   logic [23:0] cmd = '0;
   logic [63:0] resp = '0;
   logic [63:0] exp_report = '0;
   logic [63:0] exp_q[$];
   logic        oe_cap [1000];
   int          valid_rel = -1, err_rel = -1;
   int          n_checks = 0, n_fail = 0;
   bit          chk_en = 1'b0;

   // Poll lifetime in cycles after the accepting edge, up to the valid/err cycle
   function automatic int end_rel_f(input int nb, input int d);
      if (nb >= 64) return 1000 + d + 40 * 63 + 22;
      if (nb == 0)  return 2000;
      return 1000 + d + 40 * (nb - 1) + 2 + 80;
   endfunction

   function automatic logic oe_wave(input int rel);
      int  b, p;
      logic bv;
      b  = rel / 40;
      p  = rel % 40;
      bv = (b < 24) ? cmd[23 - b] : 1'b1;
      return bv ? (p < 10) : (p < 30);
   endfunction

   // Controller model: bit i falls at edge 1000+dly+40*i, low 1 us for '1', 3 us for '0'
   function automatic logic pad_at(input int k);
      int rel, x, i, p;
      if (!act) return 1'b1;
      rel = k - t0;
      x   = rel - 1000 - dly;
      if (x < 0) return 1'b1;
      i = x / 40;
      if (i >= nresp) return 1'b1;
      p = x % 40;
      return !(p < (resp[63 - i] ? 10 : 30));
   endfunction

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // ---------------- pad driver ----------------
   always @(negedge SYSCLK) data_in = pad_at(cyc + 1);

   // ---------------- per-cycle compare + scoreboard ----------------
   int   rel_c;
   bit   in_tr;
   logic e_oe, e_busy, e_valid, e_err;

   always @(negedge SYSCLK) begin
      if (chk_en) begin
         rel_c   = cyc - t0;
         in_tr   = act && rel_c >= 0 && rel_c <= end_rel;
         e_busy  = in_tr && rel_c < end_rel;
         e_valid = in_tr && rel_c == end_rel && nresp == 64;
         e_err   = in_tr && rel_c == end_rel && nresp < 64;
         e_oe    = in_tr && rel_c < 1000 && oe_wave(rel_c);
         if (e_valid) exp_report = resp;
         check($sformatf("ctl[oe,busy,valid,err]@%0d", cyc),
               {60'b0, data_oe, busy, valid, err}, {60'b0, e_oe, e_busy, e_valid, e_err});
         check($sformatf("report@%0d", cyc), report, exp_report);
         if (!in_tr) check($sformatf("state_idle@%0d", cyc), 64'(state), 64'(ST_IDLE));
         if (in_tr && rel_c < 1000) oe_cap[rel_c] = data_oe;
         if (act && rel_c >= 0 && valid === 1'b1) valid_rel = rel_c;
         if (act && rel_c >= 0 && err === 1'b1) err_rel = rel_c;
         if (valid === 1'b1) begin
            check("sb_pending", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() != 0) check("sb_report", report, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   // Entered and left at negedge+1; a zero gap asserts start in the current cycle.
   task automatic poll(input bit rum, input int nb, input int d, input logic [63:0] r,
                       input int gap, input int mid_start, input int rst_bit);
      repeat (gap) begin @(negedge SYSCLK); #1; end
      start     = 1'b1;
      rumble    = rum;
      t0        = cyc + 1;
      cmd       = {GC_CMD_POLL, 7'b0, rum};
      nresp     = nb;
      dly       = d;
      resp      = r;
      end_rel   = end_rel_f(nb, d);
      act       = 1'b1;
      valid_rel = -1;
      err_rel   = -1;
      if (nb == 64) exp_q.push_back(r);
      @(negedge SYSCLK); #1;
      start  = 1'b0;
      rumble = ~rum;
      if (mid_start > 0) begin
         while (cyc < t0 + mid_start) begin @(negedge SYSCLK); #1; end
         start = 1'b1;
         @(negedge SYSCLK); #1;
         start = 1'b0;
      end
      if (rst_bit >= 0) begin
         while (cyc < t0 + 1000 + d + 40 * rst_bit + 7) begin @(negedge SYSCLK); #1; end
         NSYSRESET  = 1'b0;
         act        = 1'b0;
         exp_report = '0;
         exp_q.delete();
         @(negedge SYSCLK); #1;
         NSYSRESET = 1'b1;
      end else begin
         while (cyc <= t0 + end_rel) begin @(negedge SYSCLK); #1; end
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // ---------------- main sequence ----------------
   int          cnt, cnt0, nb;
   logic [24:0] word;

   initial begin
      @(posedge SYSCLK);
      chk_en = 1'b1;
      repeat (3) @(negedge SYSCLK);
      #1;
      check("rst_state", 64'(state), 64'(ST_IDLE));
      check("rst_oe", 64'(data_oe), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid_err", {62'b0, valid, err}, 64'd0);
      check("rst_report", report, 64'h0);
      NSYSRESET = 1'b1;

      // Command encoding and a known good report
      poll(1'b1, 64, 20, 64'h0080_8080_8080_1F1F, 4, -1, -1);
      word = '0;
      cnt0 = 0;
      for (int b = 0; b < 25; b++) begin
         cnt = 0;
         for (int p = 0; p < 40; p++) cnt += (oe_cap[40 * b + p] === 1'b1) ? 1 : 0;
         if (b == 0) cnt0 = cnt;
         word = {word[23:0], (cnt == 10)};
      end
      check("cmd_word", 64'(word[24:1]), 64'h400301);
      check("stop_bit", 64'(word[0]), 64'd1);
      check("bit0_drive_cycles", 64'(cnt0), 64'd30);
      check("valid_cycle", 64'(valid_rel), 64'd3562);
      check("good_report", report, 64'h0080_8080_8080_1F1F);

      // No controller
      poll(1'b0, 0, 0, '0, 3, -1, -1);
      check("timeout_cycle", 64'(err_rel), 64'd2000);
      check("timeout_no_valid", 64'(valid_rel), 64'(-1));
      check("report_kept", report, 64'h0080_8080_8080_1F1F);

      // Truncated response after 40 bits
      poll(1'b0, 40, 20, rand64(), 3, -1, -1);
      check("gap_err_cycle", 64'(err_rel), 64'd2662);
      check("gap_no_valid", 64'(valid_rel), 64'(-1));

      // Second start during TX is dropped
      poll(1'b0, 64, $urandom_range(0, 300), rand64(), 2, 300, -1);

      // Reset at RX bit 30
      poll(1'b1, 64, $urandom_range(0, 100), rand64(), 5, -1, 30);
      check("midrst_state", 64'(state), 64'(ST_IDLE));
      check("midrst_oe_busy", {62'b0, data_oe, busy}, 64'd0);
      check("midrst_report", report, 64'h0);

      // Back-to-back polls
      poll(1'(($urandom & 1)), 64, $urandom_range(0, 300), rand64(), 4, -1, -1);
      poll(1'(($urandom & 1)), 64, $urandom_range(0, 300), rand64(), 0, -1, -1);

      // Randomised polls, some truncated
      for (int n = 0; n < 6; n++) begin
         nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 63) : 64;
         poll(1'(($urandom & 1)), nb, $urandom_range(0, 300), rand64(),
              $urandom_range(0, 20), -1, -1);
      end

      repeat (5) @(negedge SYSCLK);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

endmodule
